// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns engine: loads a 128-bit state, rewrites
// COLS_PER_CYCLE columns per clock in place, then holds the result until taken.
module inv_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    logic [1:0]   state_q;
    logic [1:0]   col_q;
    logic [127:0] st_q;
    logic [127:0] st_d;
    logic [31:0]  cols_q   [4];
    logic [31:0]  cols_d   [4];
    logic [31:0]  lane_in  [COLS_PER_CYCLE];
    logic [31:0]  lane_out [COLS_PER_CYCLE];
    logic         last_step;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples 9/11/13/14 are built from one x2->x4->x8 chain per byte.
    function automatic logic [31:0] inv_col(input logic [31:0] a);
        logic [7:0] m9  [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] x1, x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            x1     = a[8*i +: 8];
            x2     = xtime(x1);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m9[i]  = x8 ^ x1;
            m11[i] = x8 ^ x2 ^ x1;
            m13[i] = x8 ^ x4 ^ x1;
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m11[0] ^ m13[1] ^ m9[2]  ^ m14[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m14[0] ^ m11[1] ^ m13[2] ^ m9[3]};
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_cols
        assign cols_q[c]         = st_q[32*c +: 32];
        assign st_d[32*c +: 32]  = cols_d[c];
    end

    // Lanes are shared across the iterations; col_q steers which columns they see.
    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lanes
        assign lane_in[j]  = cols_q[col_q + 2'(j)];
        assign lane_out[j] = inv_col(lane_in[j]);
    end

    always_comb begin
        cols_d = cols_q;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            cols_d[col_q + 2'(j)] = lane_out[j];
        end
    end

    assign last_step = ({1'b0, col_q} + STEP) == 3'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            st_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        st_q    <= data_in;
                        col_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    st_q  <= st_d;
                    col_q <= col_q + STEP[1:0];
                    if (last_step) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign data_out  = st_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench for inv_mix_columns_iter: three instances (1, 2, 4 columns per clock)
// checked against a GF(2^8) matrix-multiply model of (Inv)MixColumns.
module tb_inv_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] data_in   [3];
    logic [127:0] data_out  [3];
    int           checks   = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .data_in(data_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .data_out(data_out[0]));
    inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .data_in(data_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .data_out(data_out[1]));
    inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .data_in(data_in[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .data_out(data_out[2]));

    function automatic int nlat(input int k);
        return 4 >> k;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Generic shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Circulant matrix product per column; row0 byte k is the coefficient of a_k in b_0.
    function automatic logic [127:0] mix_with(input logic [127:0] s, input logic [31:0] row0);
        logic [127:0] r;
        logic [7:0]   acc;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gmul(row0[8*((k - row + 4) % 4) +: 8], s[32*c + 8*k +: 8]);
                end
                r[32*c + 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_inv_mix(input logic [127:0] s);
        return mix_with(s, {8'd9, 8'd13, 8'd11, 8'd14});
    endfunction

    function automatic logic [127:0] ref_fwd_mix(input logic [127:0] s);
        return mix_with(s, {8'd1, 8'd1, 8'd3, 8'd2});
    endfunction

    // Drives one accept on instance k and consumes the result; all checking is left to the caller.
    task automatic run_block(input int k, input logic [127:0] d, output int lat,
                             output logic [127:0] got, output logic idle_after);
        int w;
        w = 0;
        while (in_ready[k] !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        in_valid[k] = 1'b1;
        data_in[k]  = d;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        data_in[k]  = rand128();
        lat = 0;
        while (out_valid[k] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        got = data_out[k];
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        idle_after = (out_valid[k] === 1'b0) && (in_ready[k] === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || data_out[k] !== '0) begin
                failures++;
                $display("[TB] FAIL reset_state[%0d]: got out_valid=%b in_ready=%b data_out=%h expected 0/1/0",
                         k, out_valid[k], in_ready[k], data_out[k]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL post_reset_idle[%0d]: got out_valid=%b in_ready=%b expected 0/1",
                         k, out_valid[k], in_ready[k]);
            end
        end
    endtask

    task automatic test_fips();
        int           lat;
        logic [127:0] got;
        logic         idle;
        for (int k = 0; k < 3; k++) begin
            run_block(k, {4{32'hbca14d8e}}, lat, got, idle);
            checks++;
            if (lat != nlat(k)) begin
                failures++;
                $display("[TB] FAIL fips_latency[%0d]: got %0d expected %0d", k, lat, nlat(k));
            end
            checks++;
            if (got !== {4{32'h455313db}}) begin
                failures++;
                $display("[TB] FAIL fips_data[%0d]: got %h expected %h", k, got, {4{32'h455313db}});
            end
            checks++;
            if (idle !== 1'b1) begin
                failures++;
                $display("[TB] FAIL fips_release[%0d]: got %b expected 1", k, idle);
            end
        end
    endtask

    // The f2 0a 22 5c column's often-quoted image is its forward MixColumns value,
    // so the whole block is compared to the model and the other three columns to constants.
    task automatic test_mixed();
        int           lat;
        logic [127:0] got;
        logic         idle;
        logic [127:0] d;
        logic [127:0] exp;
        d   = {32'h5c220af2, 32'hd6d7d5d5, 32'h01010101, 32'hc6c6c6c6};
        exp = ref_inv_mix(d);
        for (int k = 0; k < 3; k++) begin
            run_block(k, d, lat, got, idle);
            checks++;
            if (lat != nlat(k)) begin
                failures++;
                $display("[TB] FAIL mixed_latency[%0d]: got %0d expected %0d", k, lat, nlat(k));
            end
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL mixed_data[%0d]: got %h expected %h", k, got, exp);
            end
            checks++;
            if (got[95:0] !== 96'hd5d4d4d4_01010101_c6c6c6c6) begin
                failures++;
                $display("[TB] FAIL mixed_known_cols[%0d]: got %h expected d5d4d4d401010101c6c6c6c6",
                         k, got[95:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        logic [127:0] exp;
        int           lat;
        d   = rand128();
        exp = ref_inv_mix(d);
        checks++;
        if (in_ready[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_idle: got in_ready=%b expected 1", in_ready[0]);
        end
        in_valid[0] = 1'b1;
        data_in[0]  = d;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        lat = 0;
        while (out_valid[0] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat != 4) begin
            failures++;
            $display("[TB] FAIL bp_latency: got %0d expected 4", lat);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = 1'($urandom_range(1));
            data_in[0]  = rand128();
            @(posedge clk); #1;
            checks++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || data_out[0] !== exp) begin
                failures++;
                $display("[TB] FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b data=%h expected 1/0/%h",
                         i, out_valid[0], in_ready[0], data_out[0], exp);
            end
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL bp_no_ghost[%0d]: got out_valid=%b in_ready=%b expected 0/1",
                         i, out_valid[0], in_ready[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back(input int k);
        logic [127:0] blocks [3];
        int           acc_cyc[$];
        int           outs;
        int           idx;
        logic         acc;
        logic [127:0] exp;
        for (int i = 0; i < 3; i++) blocks[i] = rand128();
        idx          = 0;
        outs         = 0;
        out_ready[k] = 1'b1;
        in_valid[k]  = 1'b1;
        data_in[k]   = blocks[0];
        for (int cyc = 0; cyc < 60; cyc++) begin
            acc = in_ready[k] && in_valid[k];
            if (out_valid[k] === 1'b1) begin
                checks++;
                if (outs >= 3) begin
                    failures++;
                    $display("[TB] FAIL b2b_extra[%0d]: got output #%0d expected only 3", k, outs + 1);
                end else begin
                    exp = ref_inv_mix(blocks[outs]);
                    if (data_out[k] !== exp) begin
                        failures++;
                        $display("[TB] FAIL b2b_data[%0d.%0d]: got %h expected %h", k, outs, data_out[k], exp);
                    end
                end
                outs++;
            end
            @(posedge clk); #1;
            if (acc) begin
                acc_cyc.push_back(cyc);
                idx++;
                if (idx < 3) data_in[k] = blocks[idx];
                else         in_valid[k] = 1'b0;
            end
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        checks++;
        if (outs != 3) begin
            failures++;
            $display("[TB] FAIL b2b_count[%0d]: got %0d expected 3", k, outs);
        end
        checks++;
        if (acc_cyc.size() != 3) begin
            failures++;
            $display("[TB] FAIL b2b_accepts[%0d]: got %0d expected 3", k, acc_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] != nlat(k) + 2) begin
                    failures++;
                    $display("[TB] FAIL b2b_interval[%0d.%0d]: got %0d expected %0d",
                             k, i, acc_cyc[i] - acc_cyc[i-1], nlat(k) + 2);
                end
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        int           lat;
        logic [127:0] got;
        logic         idle;
        logic [127:0] d;
        in_valid[0] = 1'b1;
        data_in[0]  = rand128() | 128'h1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || data_out[0] !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_async: got out_valid=%b data=%h expected 0/0", out_valid[0], data_out[0]);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL midreset_idle[%0d]: got in_ready=%b out_valid=%b expected 1/0",
                         i, in_ready[0], out_valid[0]);
            end
        end
        d = rand128();
        run_block(0, d, lat, got, idle);
        checks++;
        if (lat != 4 || got !== ref_inv_mix(d)) begin
            failures++;
            $display("[TB] FAIL midreset_next: got lat=%0d data=%h expected 4/%h", lat, got, ref_inv_mix(d));
        end
    endtask

    task automatic test_roundtrip();
        int           lat;
        logic [127:0] got;
        logic         idle;
        logic [127:0] orig;
        int           k;
        for (int i = 0; i <= 1000; i++) begin
            k    = i % 3;
            orig = (i == 1000) ? 128'h0 : rand128();
            run_block(k, ref_fwd_mix(orig), lat, got, idle);
            checks++;
            if (got !== orig || lat != nlat(k) || idle !== 1'b1) begin
                failures++;
                $display("[TB] FAIL roundtrip[%0d]: got data=%h lat=%0d idle=%b expected %h/%0d/1",
                         i, got, lat, idle, orig, nlat(k));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            data_in[k]   = '0;
        end
        rst_n = 1'b1;
        #1;
        test_reset();
        test_fips();
        test_mixed();
        test_backpressure();
        test_back_to_back(0);
        test_back_to_back(1);
        test_back_to_back(2);
        test_reset_mid_busy();
        test_roundtrip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
